// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo controller, datapath and ALU:
// ALU operation codes, FSM state encoding and the controller output bundle.
package modulo_pkg;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_LT  = 3'd2;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    INIT   = 4'd2,
    CMP    = 4'd3,
    CMP_WB = 4'd4,
    CHECK  = 4'd5,
    SUB    = 4'd6,
    SUB_WB = 4'd7,
    DONE   = 4'd8
  } state_t;

  typedef struct packed {
    logic [2:0] alu_mode;
    logic       wren_update_zahlen;
    logic       wren_zahl1_to_erg;
    logic       wren_term_erg;
    logic       wren_res_to_erg;
    logic       erg_to_alu_a;
    logic       zahl2_to_alu_b;
    logic       check_for_termination;
    logic       busy;
    logic       done;
    logic       error;
  } ctrl_out_t;

  // Moore output decode; err only matters in DONE (abort via iteration limit).
  function automatic ctrl_out_t decode_outputs(input state_t s, input logic err);
    ctrl_out_t o;
    o = '0;
    case (s)
      IDLE: begin
        o = '0;
      end
      LOAD: begin
        o.wren_update_zahlen = 1'b1;
        o.busy               = 1'b1;
      end
      INIT: begin
        o.wren_zahl1_to_erg = 1'b1;
        o.busy              = 1'b1;
      end
      CMP: begin
        o.alu_mode       = ALU_LT;
        o.erg_to_alu_a   = 1'b1;
        o.zahl2_to_alu_b = 1'b1;
        o.busy           = 1'b1;
      end
      CMP_WB: begin
        o.alu_mode       = ALU_LT;
        o.erg_to_alu_a   = 1'b1;
        o.zahl2_to_alu_b = 1'b1;
        o.wren_term_erg  = 1'b1;
        o.busy           = 1'b1;
      end
      CHECK: begin
        o.check_for_termination = 1'b1;
        o.busy                  = 1'b1;
      end
      SUB: begin
        o.alu_mode       = ALU_SUB;
        o.erg_to_alu_a   = 1'b1;
        o.zahl2_to_alu_b = 1'b1;
        o.busy           = 1'b1;
      end
      SUB_WB: begin
        o.alu_mode        = ALU_SUB;
        o.erg_to_alu_a    = 1'b1;
        o.zahl2_to_alu_b  = 1'b1;
        o.wren_res_to_erg = 1'b1;
        o.busy            = 1'b1;
      end
      DONE: begin
        o.done  = 1'b1;
        o.error = err;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_modulo.sv
// 16-bit ALU with an ALU_LAT-deep output pipeline. Supports signed
// less-than (result 1/0) and subtraction.
module alu_modulo
  import modulo_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [2:0]  mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  logic [15:0] res_s;
  logic [15:0] pipe_r [ALU_LAT];

  // Combinational operation select
  always_comb begin
    res_s = 16'd0;
    case (mode)
      ALU_SUB: res_s = a - b;
      ALU_LT:  res_s = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      ALU_NOP: res_s = 16'd0;
      default: res_s = 16'd0;
    endcase
  end

  // Latency pipeline: result appears ALU_LAT cycles after operands/mode
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe_r[i] <= 16'd0;
      end
    end else begin
      pipe_r[0] <= res_s;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign result = pipe_r[ALU_LAT-1];

endmodule

// File: rtl/controller_modulo_chk.sv
// Property checker for controller_modulo port behaviour.
module controller_modulo_chk (
  input logic clk,
  input logic rst_i,
  input logic start_i,
  input logic wren_update_Zahlen_o,
  input logic wren_Zahl1_to_erg_o,
  input logic wren_term_erg_o,
  input logic wren_res_to_erg_o,
  input logic busy_o,
  input logic done_o,
  input logic error_o
);

  // Register-file write enables are mutually exclusive
  a_wren_onehot0: assert property (@(posedge clk) disable iff (rst_i)
    $onehot0({wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o}));

  // A start while busy must never restart the operand load
  a_start_ignored: assert property (@(posedge clk) disable iff (rst_i)
    (busy_o && start_i) |=> !wren_update_Zahlen_o);

  // Abort pulse only ever accompanies completion
  a_error_with_done: assert property (@(posedge clk) disable iff (rst_i)
    error_o |-> done_o);

endmodule

// File: rtl/datapath_modulo.sv
// Operand, result and termination-bit registers around alu_modulo.
// valid is the stored compare bit qualified by the controller's check strobe.
module datapath_modulo
  import modulo_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [15:0] zahl1,
  input  logic [15:0] zahl2,
  input  logic [2:0]  alu_mode,
  input  logic        wren_update_zahlen,
  input  logic        wren_zahl1_to_erg,
  input  logic        wren_term_erg,
  input  logic        wren_res_to_erg,
  input  logic        erg_to_alu_a,
  input  logic        zahl2_to_alu_b,
  input  logic        check_for_termination,
  output logic        valid,
  output logic [15:0] ergebnis
);

  logic [15:0] zahl1_r;
  logic [15:0] zahl2_r;
  logic [15:0] erg_r;
  logic        term_r;
  logic [15:0] alu_a_s;
  logic [15:0] alu_b_s;
  logic [15:0] alu_res_s;

  assign alu_a_s = erg_to_alu_a   ? erg_r   : 16'd0;
  assign alu_b_s = zahl2_to_alu_b ? zahl2_r : 16'd0;

  alu_modulo #(.ALU_LAT(ALU_LAT)) u_alu (
    .clk    (clk),
    .rst_i  (rst_i),
    .mode   (alu_mode),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_res_s)
  );

  // Operand capture
  always_ff @(posedge clk) begin
    if (rst_i) begin
      zahl1_r <= 16'd0;
      zahl2_r <= 16'd0;
    end else if (wren_update_zahlen) begin
      zahl1_r <= zahl1;
      zahl2_r <= zahl2;
    end else begin
      zahl1_r <= zahl1_r;
      zahl2_r <= zahl2_r;
    end
  end

  // Result register: initialised from Zahl1, then updated by subtraction
  always_ff @(posedge clk) begin
    if (rst_i) begin
      erg_r <= 16'd0;
    end else if (wren_zahl1_to_erg) begin
      erg_r <= zahl1_r;
    end else if (wren_res_to_erg) begin
      erg_r <= alu_res_s;
    end else begin
      erg_r <= erg_r;
    end
  end

  // Termination bit from the less-than compare
  always_ff @(posedge clk) begin
    if (rst_i) begin
      term_r <= 1'b0;
    end else if (wren_term_erg) begin
      term_r <= alu_res_s[0];
    end else begin
      term_r <= term_r;
    end
  end

  assign valid    = check_for_termination & term_r;
  assign ergebnis = erg_r;

endmodule

// File: rtl/controller_modulo.sv
// Moore controller for Zahl1 mod Zahl2 by repeated subtraction.
// Outputs are registered together with the state, so every output is the
// decode of the state currently held.
module controller_modulo
  import modulo_pkg::*;
#(
  parameter int          ALU_LAT  = 2,
  parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       valid_i,
  output logic [2:0] alu_mode_o,
  output logic       wren_update_Zahlen_o,
  output logic       wren_Zahl1_to_erg_o,
  output logic       wren_term_erg_o,
  output logic       wren_res_to_erg_o,
  output logic       erg_to_alu_a_o,
  output logic       Zahl2_to_alu_b_o,
  output logic       check_for_termination_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [2:0] WAIT_LAST = 3'(ALU_LAT - 1);

  state_t      state_r;
  logic [2:0]  wait_r;
  logic [15:0] iter_r;
  ctrl_out_t   out_r;
  logic [15:0] iter_inc_s;

  // Iteration counter saturates instead of wrapping
  assign iter_inc_s = (iter_r == 16'hFFFF) ? iter_r : (iter_r + 16'd1);

  // State, counters and registered outputs advance together
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r <= IDLE;
      wait_r  <= 3'd0;
      iter_r  <= 16'd0;
      out_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r <= LOAD;
            out_r   <= decode_outputs(LOAD, 1'b0);
          end else begin
            state_r <= IDLE;
            out_r   <= decode_outputs(IDLE, 1'b0);
          end
        end
        LOAD: begin
          state_r <= INIT;
          out_r   <= decode_outputs(INIT, 1'b0);
        end
        INIT: begin
          iter_r  <= 16'd0;
          wait_r  <= 3'd0;
          state_r <= CMP;
          out_r   <= decode_outputs(CMP, 1'b0);
        end
        CMP: begin
          if (wait_r == WAIT_LAST) begin
            wait_r  <= 3'd0;
            state_r <= CMP_WB;
            out_r   <= decode_outputs(CMP_WB, 1'b0);
          end else begin
            wait_r  <= wait_r + 3'd1;
            state_r <= CMP;
            out_r   <= decode_outputs(CMP, 1'b0);
          end
        end
        CMP_WB: begin
          state_r <= CHECK;
          out_r   <= decode_outputs(CHECK, 1'b0);
        end
        CHECK: begin
          if (valid_i) begin
            state_r <= DONE;
            out_r   <= decode_outputs(DONE, 1'b0);
          end else if (iter_r == MAX_ITER) begin
            state_r <= DONE;
            out_r   <= decode_outputs(DONE, 1'b1);
          end else begin
            wait_r  <= 3'd0;
            state_r <= SUB;
            out_r   <= decode_outputs(SUB, 1'b0);
          end
        end
        SUB: begin
          if (wait_r == WAIT_LAST) begin
            wait_r  <= 3'd0;
            state_r <= SUB_WB;
            out_r   <= decode_outputs(SUB_WB, 1'b0);
          end else begin
            wait_r  <= wait_r + 3'd1;
            state_r <= SUB;
            out_r   <= decode_outputs(SUB, 1'b0);
          end
        end
        SUB_WB: begin
          iter_r  <= iter_inc_s;
          wait_r  <= 3'd0;
          state_r <= CMP;
          out_r   <= decode_outputs(CMP, 1'b0);
        end
        DONE: begin
          state_r <= IDLE;
          out_r   <= decode_outputs(IDLE, 1'b0);
        end
        default: begin
          wait_r  <= 3'd0;
          iter_r  <= 16'd0;
          state_r <= IDLE;
          out_r   <= '0;
        end
      endcase
    end
  end

  assign alu_mode_o              = out_r.alu_mode;
  assign wren_update_Zahlen_o    = out_r.wren_update_zahlen;
  assign wren_Zahl1_to_erg_o     = out_r.wren_zahl1_to_erg;
  assign wren_term_erg_o         = out_r.wren_term_erg;
  assign wren_res_to_erg_o       = out_r.wren_res_to_erg;
  assign erg_to_alu_a_o          = out_r.erg_to_alu_a;
  assign Zahl2_to_alu_b_o        = out_r.zahl2_to_alu_b;
  assign check_for_termination_o = out_r.check_for_termination;
  assign busy_o                  = out_r.busy;
  assign done_o                  = out_r.done;
  assign error_o                 = out_r.error;

endmodule

// File: doc/controller_modulo.md
CONTROLLER_MODULO -- requirements
Module: controller_modulo

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2: cycles from operand-select/mode drive to a valid ALU result on the write-back bus (1..7).
REQ-002 SHALL have parameter MAX_ITER, default 16'hFFFF: maximum subtraction iterations before abort.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; operands must be stable on the datapath in this cycle.
- valid_i  in  1  termination flag returned by the datapath (check AND stored compare bit).
- alu_mode_o  out  3  ALU operation select.
- wren_update_Zahlen_o  out  1  load operand registers.
- wren_Zahl1_to_erg_o  out  1  copy Zahl1 into the result register.
- wren_term_erg_o  out  1  store ALU bit0 as termination bit.
- wren_res_to_erg_o  out  1  store ALU result into the result register.
- erg_to_alu_a_o  out  1  result register to ALU operand A.
- Zahl2_to_alu_b_o  out  1  Zahl2 to ALU operand B.
- check_for_termination_o  out  1  qualifies valid_i.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  one-cycle abort pulse, coincident with done_o.

Function
REQ-004 SHALL compute Zahl1 mod Zahl2 by repeated subtraction: erg = Zahl1; while !(erg < Zahl2): erg = erg - Zahl2.
REQ-005 SHALL implement Moore states IDLE, LOAD, INIT, CMP, CMP_WB, CHECK, SUB, SUB_WB, DONE; all outputs are functions of state and wait counter only.
REQ-006 IDLE: all outputs 0; start_i=1 -> LOAD next cycle.
REQ-007 LOAD (1 cycle): wren_update_Zahlen_o=1; -> INIT.
REQ-008 INIT (1 cycle): wren_Zahl1_to_erg_o=1; iteration counter cleared; -> CMP.
REQ-009 CMP (ALU_LAT cycles): alu_mode_o=ALU_LT, erg_to_alu_a_o=1, Zahl2_to_alu_b_o=1; -> CMP_WB.
REQ-010 CMP_WB (1 cycle): wren_term_erg_o=1, selects and mode still held; -> CHECK.
REQ-011 CHECK (1 cycle): check_for_termination_o=1; valid_i=1 -> DONE; else iteration count == MAX_ITER -> DONE with error; else -> SUB.
REQ-012 SUB (ALU_LAT cycles): alu_mode_o=ALU_SUB, erg_to_alu_a_o=1, Zahl2_to_alu_b_o=1; -> SUB_WB.
REQ-013 SUB_WB (1 cycle): wren_res_to_erg_o=1, selects and mode held; iteration counter +1 (16-bit, saturating); -> CMP.
REQ-014 DONE (1 cycle): done_o=1, busy_o=0, error_o=1 only if entered via iteration limit; -> IDLE.
REQ-015 busy_o SHALL be 1 in LOAD through SUB_WB, 0 in IDLE and DONE.
REQ-016 At most one wren_*_o SHALL be 1 in any cycle.
REQ-017 start_i SHALL be ignored outside IDLE; start_i in DONE is not queued.
REQ-018 Total busy cycles for n subtractions SHALL be 2 + (n+1)(ALU_LAT+2) + n(ALU_LAT+1); with ALU_LAT=2: 6 + 7n.
REQ-019 Operands SHALL be treated as signed 16-bit, valid range 0..32767; negative inputs are out of scope; Zahl2=0 terminates only via MAX_ITER.

Reset
REQ-020 rst_i=1 on a clock edge SHALL force IDLE, clear wait and iteration counters, and drive every output to 0 the following cycle, including mid-operation.
REQ-021 No done_o or error_o pulse SHALL be produced for an operation aborted by reset.

Structure
REQ-022 Shared package modulo_pkg SHALL hold ALU mode constants (ALU_NOP=3'd0, ALU_SUB=3'd1, ALU_LT=3'd2) and the state encoding; alu_modulo decodes the same constants.
REQ-023 No sub-module is needed: the ALU-latency wait counter (3-bit) and the iteration counter are inline.

Verification (bench instantiates controller_modulo + datapath_modulo + alu_modulo, ALU_LAT=2)
REQ-024 Zahl1=17, Zahl2=5, start pulse -> busy_o for 27 cycles, done_o pulse, ergebnis=2, error_o=0.
REQ-025 Zahl1=4, Zahl2=9 -> busy_o for 6 cycles, no SUB state entered, ergebnis=4.
REQ-026 Zahl1=20, Zahl2=5 -> 4 subtractions, busy_o for 34 cycles, ergebnis=0.
REQ-027 MAX_ITER=4, Zahl1=3, Zahl2=0 -> after 4 SUB_WB cycles: done_o=1 and error_o=1 in the same cycle.
REQ-028 rst_i asserted in SUB during 17 mod 5, start_i re-issued with 10 mod 3 -> first run gives no done_o; second gives ergebnis=1 after 27 busy cycles.
REQ-029 Every cycle, all runs: assertion that at most one wren_*_o is 1, and that start_i while busy_o=1 changes nothing.
